// File: rtl/reg_wb_arbiter_pkg.sv
// Shared types and constants for the register-file writeback arbiter.
// Optional build macro used elsewhere in this slice: REG_WB_FWD_EN.
package reg_wb_pkg;

  localparam int XLEN   = 32;
  localparam int REG_AW = 5;
  localparam int NREGS  = 1 << REG_AW;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    HOLD = 2'd2
  } arb_state_e;

  // Counter width able to hold the value max_wait itself
  function automatic int cnt_width(input int max_wait);
    return (max_wait < 1) ? 1 : $clog2(max_wait + 1);
  endfunction

endpackage

// File: rtl/reg_wb_arbiter_if.sv
// Bus bundle between WB / MUL-DIV / decode and the writeback arbiter.
// REG_WB_FWD_EN adds the operand forwarding outputs.
interface reg_wb_arbiter_if;
  import reg_wb_pkg::*;

  logic              wb_valid;
  logic [REG_AW-1:0] wb_addr;
  logic [XLEN-1:0]   wb_data;
  logic              md_valid;
  logic [REG_AW-1:0] md_addr;
  logic [XLEN-1:0]   md_data;
  logic              md_ready;
  logic              issue_valid;
  logic [REG_AW-1:0] issue_addr;
  logic              dec_valid;
  logic [REG_AW-1:0] rs1_addr;
  logic [REG_AW-1:0] rs2_addr;
  logic [REG_AW-1:0] rd_addr;
  logic              hazard;
  logic              pipe_hold;
  logic              reg_write_en;
  logic [REG_AW-1:0] reg_inaddress;
  logic [XLEN-1:0]   reg_in;
  logic [NREGS-1:0]  pending;
`ifdef REG_WB_FWD_EN
  logic              fwd1_hit;
  logic              fwd2_hit;
  logic [XLEN-1:0]   fwd1_data;
  logic [XLEN-1:0]   fwd2_data;

  modport slave (
    input  wb_valid, wb_addr, wb_data, md_valid, md_addr, md_data,
    input  issue_valid, issue_addr, dec_valid, rs1_addr, rs2_addr, rd_addr,
    output md_ready, hazard, pipe_hold, reg_write_en, reg_inaddress, reg_in, pending,
    output fwd1_hit, fwd2_hit, fwd1_data, fwd2_data
  );

  modport master (
    output wb_valid, wb_addr, wb_data, md_valid, md_addr, md_data,
    output issue_valid, issue_addr, dec_valid, rs1_addr, rs2_addr, rd_addr,
    input  md_ready, hazard, pipe_hold, reg_write_en, reg_inaddress, reg_in, pending,
    input  fwd1_hit, fwd2_hit, fwd1_data, fwd2_data
  );
`else
  modport slave (
    input  wb_valid, wb_addr, wb_data, md_valid, md_addr, md_data,
    input  issue_valid, issue_addr, dec_valid, rs1_addr, rs2_addr, rd_addr,
    output md_ready, hazard, pipe_hold, reg_write_en, reg_inaddress, reg_in, pending
  );

  modport master (
    output wb_valid, wb_addr, wb_data, md_valid, md_addr, md_data,
    output issue_valid, issue_addr, dec_valid, rs1_addr, rs2_addr, rd_addr,
    input  md_ready, hazard, pipe_hold, reg_write_en, reg_inaddress, reg_in, pending
  );
`endif

endinterface

// File: rtl/reg_wb_arbiter_scoreboard.sv
// Pending-write scoreboard for outstanding MUL/DIV destinations,
// with a hit lookup for the three decode-stage register addresses.
module reg_scoreboard
  import reg_wb_pkg::*;
(
  input  logic              clk,
  input  logic              reset,
  input  logic              set_en,
  input  logic [REG_AW-1:0] set_addr,
  input  logic              clr_en,
  input  logic [REG_AW-1:0] clr_addr,
  input  logic [REG_AW-1:0] rs1_addr,
  input  logic [REG_AW-1:0] rs2_addr,
  input  logic [REG_AW-1:0] rd_addr,
  output logic [NREGS-1:0]  pending,
  output logic [2:0]        pend_hit
);

  logic [NREGS-1:0] pending_q;
  logic [NREGS-1:0] pending_d;
  logic [NREGS-1:0] set_mask;
  logic [NREGS-1:0] clr_mask;

  // Next pending vector: clear on handshake, then set on issue so set wins; x0 never tracked
  always_comb begin
    set_mask = '0;
    clr_mask = '0;
    if (set_en && (set_addr != '0)) set_mask[set_addr] = 1'b1;
    if (clr_en && (clr_addr != '0)) clr_mask[clr_addr] = 1'b1;
    pending_d = (pending_q & ~clr_mask) | set_mask;
  end

  // Pending vector register
  always_ff @(posedge clk) begin
    if (reset) pending_q <= '0;
    else       pending_q <= pending_d;
  end

  // Lookup of rs1/rs2/rd against the registered pending bits; x0 never hits
  always_comb begin
    pend_hit[0] = (rs1_addr != '0) && pending_q[rs1_addr];
    pend_hit[1] = (rs2_addr != '0) && pending_q[rs2_addr];
    pend_hit[2] = (rd_addr  != '0) && pending_q[rd_addr];
  end

  assign pending = pending_q;

endmodule

// File: rtl/reg_wb_arbiter.sv
// Writeback arbiter for the RV32IM register file write port: WB stage vs
// MUL/DIV unit, with starvation guard (pipeline freeze) and decode hazards.
// REG_WB_FWD_EN: forward RS1/RS2 matches on WB input / write stage instead of stalling.
module reg_wb_arbiter
  import reg_wb_pkg::*;
#(
  parameter int MAX_WAIT = 4
) (
  input  logic             clk,
  input  logic             reset,
  reg_wb_arbiter_if.slave  bus
);

  localparam int            CW      = cnt_width(MAX_WAIT);
  localparam logic [CW-1:0] MAX_CNT = CW'(MAX_WAIT);
  localparam logic [CW-1:0] ONE_CNT = CW'(1);

  arb_state_e        state_q;
  logic [CW-1:0]     cnt_q;
  logic              pipe_hold_q;

  logic              reg_write_en_q, reg_write_en_d;
  logic [REG_AW-1:0] reg_inaddress_q, reg_inaddress_d;
  logic [XLEN-1:0]   reg_in_q, reg_in_d;

  logic              wb_req, in_hold, md_ready, md_stall, grant_wb, md_write;
  logic              wb_hit1, wb_hit2, ws_hit1, ws_hit2, hazard;
  logic [NREGS-1:0]  pending;
  logic [2:0]        pend_hit;

  // Port arbitration: WB wins unless frozen; x0 requests never claim the port
  always_comb begin
    wb_req   = bus.wb_valid && (bus.wb_addr != '0);
    in_hold  = (state_q == HOLD);
    md_ready = !reset && bus.md_valid && (in_hold || !wb_req);
    md_stall = !reset && bus.md_valid && !md_ready;
    grant_wb = !reset && !in_hold && wb_req;
    md_write = md_ready && (bus.md_addr != '0);
  end

  // Next write-port contents; address/data hold their value when nothing is granted
  always_comb begin
    reg_write_en_d  = 1'b0;
    reg_inaddress_d = reg_inaddress_q;
    reg_in_d        = reg_in_q;
    if (grant_wb) begin
      reg_write_en_d  = 1'b1;
      reg_inaddress_d = bus.wb_addr;
      reg_in_d        = bus.wb_data;
    end else if (md_write) begin
      reg_write_en_d  = 1'b1;
      reg_inaddress_d = bus.md_addr;
      reg_in_d        = bus.md_data;
    end
  end

  // Registered write port toward the register file
  always_ff @(posedge clk) begin
    if (reset) begin
      reg_write_en_q  <= 1'b0;
      reg_inaddress_q <= '0;
      reg_in_q        <= '0;
    end else begin
      reg_write_en_q  <= reg_write_en_d;
      reg_inaddress_q <= reg_inaddress_d;
      reg_in_q        <= reg_in_d;
    end
  end

  // Starvation FSM: count consecutive MD stalls, freeze the pipe after MAX_WAIT of them
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      pipe_hold_q <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (md_stall) begin
            cnt_q <= ONE_CNT;
            if (MAX_CNT == ONE_CNT) begin
              state_q     <= HOLD;
              pipe_hold_q <= 1'b1;
            end else begin
              state_q <= WAIT;
            end
          end
        end
        WAIT: begin
          if (md_stall) begin
            cnt_q <= cnt_q + ONE_CNT;
            if ((cnt_q + ONE_CNT) == MAX_CNT) begin
              state_q     <= HOLD;
              pipe_hold_q <= 1'b1;
            end
          end else begin
            state_q <= IDLE;
            cnt_q   <= '0;
          end
        end
        HOLD: begin
          if (md_ready || !bus.md_valid) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            pipe_hold_q <= 1'b0;
          end
        end
        default: begin
          state_q     <= IDLE;
          cnt_q       <= '0;
          pipe_hold_q <= 1'b0;
        end
      endcase
    end
  end

  reg_scoreboard u_scoreboard (
    .clk      (clk),
    .reset    (reset),
    .set_en   (bus.issue_valid),
    .set_addr (bus.issue_addr),
    .clr_en   (md_ready),
    .clr_addr (bus.md_addr),
    .rs1_addr (bus.rs1_addr),
    .rs2_addr (bus.rs2_addr),
    .rd_addr  (bus.rd_addr),
    .pending  (pending),
    .pend_hit (pend_hit)
  );

  // Decode hazard: pending hits always stall; source matches on WB input or write stage stall unless forwarded
  always_comb begin
    wb_hit1 = wb_req && (bus.wb_addr == bus.rs1_addr);
    wb_hit2 = wb_req && (bus.wb_addr == bus.rs2_addr);
    ws_hit1 = reg_write_en_q && (bus.rs1_addr != '0) && (reg_inaddress_q == bus.rs1_addr);
    ws_hit2 = reg_write_en_q && (bus.rs2_addr != '0) && (reg_inaddress_q == bus.rs2_addr);
`ifdef REG_WB_FWD_EN
    hazard  = !reset && bus.dec_valid && (|pend_hit);
`else
    hazard  = !reset && bus.dec_valid &&
              ((|pend_hit) || wb_hit1 || wb_hit2 || ws_hit1 || ws_hit2);
`endif
  end

`ifdef REG_WB_FWD_EN
  assign bus.fwd1_hit  = wb_hit1 || ws_hit1;
  assign bus.fwd2_hit  = wb_hit2 || ws_hit2;
  assign bus.fwd1_data = wb_hit1 ? bus.wb_data : reg_in_q;
  assign bus.fwd2_data = wb_hit2 ? bus.wb_data : reg_in_q;
`endif

  assign bus.md_ready      = md_ready;
  assign bus.hazard        = hazard;
  assign bus.pipe_hold     = pipe_hold_q;
  assign bus.reg_write_en  = reg_write_en_q;
  assign bus.reg_inaddress = reg_inaddress_q;
  assign bus.reg_in        = reg_in_q;
  assign bus.pending       = pending;

endmodule
